// File: rtl/exmem_stage_reg.sv
// exmem_stage_reg
//   EX/MEM pipeline register with valid/ready handshake, stall and flush.
//   Captures the EX payload and presents it to MEM one cycle later, along
//   with MEM strobes decoded from the control word and gated by out_valid.
//
// Optional feature: define EXMEM_SKID_EN to compile in a second (skid)
//   entry. in_ready then comes from a register, which removes the
//   out_ready -> in_ready combinational path. Without the macro, in_ready
//   is out_ready | ~out_valid.
//
// Ports:
//   clk, reset         clock (rising edge); async active-high reset
//   in_valid/in_ready  EX-side handshake
//   ex_*               EX payload (ctrl, pa, alu, rd, pc8, r31)
//   flush              squash all held entries (beats a same-cycle accept)
//   out_ready          MEM consumes the head; low = stall
//   out_valid, mem_*   head entry and its payload
//   mem_size, mem_se, mem_rw, mem_enable, rf_enable, load_instr
//                      decoded strobes (all but mem_size gated by out_valid)
//   stall_cycles       saturating count of out_valid & ~out_ready cycles
module exmem_stage_reg #(
    parameter int CTRL_W = 22,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int PC8_W  = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic [DATA_W-1:0] ex_pa,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic [PC8_W-1:0]  ex_pc8,
    input  logic [4:0]        ex_r31,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [DATA_W-1:0] mem_pa,
    output logic [DATA_W-1:0] mem_alu,
    output logic [RD_W-1:0]   mem_rd,
    output logic [PC8_W-1:0]  mem_pc8,
    output logic [4:0]        mem_r31,
    output logic [1:0]        mem_size,
    output logic              mem_se,
    output logic              mem_rw,
    output logic              mem_enable,
    output logic              rf_enable,
    output logic              load_instr,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] pa;
        logic [DATA_W-1:0] alu;
        logic [RD_W-1:0]   rd;
        logic [PC8_W-1:0]  pc8;
        logic [4:0]        r31;
    } ent_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    ent_t             w_in;
    ent_t             r_head;
    logic             w_accept;
    logic             w_pop;
    logic             w_head_ld_in;
    logic [CNT_W-1:0] r_stall;
`ifdef EXMEM_SKID_EN
    ent_t             r_skid;
    logic             w_skid_ld;
    logic             w_head_ld_skid;
`endif

    assign w_in = '{ctrl: ex_ctrl, pa: ex_pa, alu: ex_alu,
                    rd: ex_rd, pc8: ex_pc8, r31: ex_r31};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_EMPTY;
        else       r_state <= w_next;
    end

    // Next-state and datapath load enables
    always_comb begin
        w_next       = r_state;
        w_head_ld_in = 1'b0;
`ifdef EXMEM_SKID_EN
        w_skid_ld      = 1'b0;
        w_head_ld_skid = 1'b0;
`endif
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_next       = S_ONE;
                    w_head_ld_in = 1'b1;
                end
            end
            S_ONE: begin
                // Without a skid, in_ready equals out_ready here, so an
                // accept always coincides with a pop.
                if (w_pop && w_accept) w_head_ld_in = 1'b1;
                else if (w_pop)        w_next = S_EMPTY;
`ifdef EXMEM_SKID_EN
                else if (w_accept) begin
                    w_next    = S_TWO;
                    w_skid_ld = 1'b1;
                end
`endif
            end
`ifdef EXMEM_SKID_EN
            S_TWO: begin
                // in_ready is low in TWO, so only a pop can happen.
                if (w_pop) begin
                    w_next         = S_ONE;
                    w_head_ld_skid = 1'b1;
                end
            end
`endif
            default: w_next = S_EMPTY;
        endcase
        // Flush wins; anything loaded this cycle is left as stale data.
        if (flush) w_next = S_EMPTY;
    end

    // Handshake outputs
    always_comb begin
        out_valid = (r_state != S_EMPTY);
`ifdef EXMEM_SKID_EN
        in_ready  = (r_state != S_TWO);
`else
        in_ready  = out_ready | (r_state == S_EMPTY);
`endif
    end

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    // Payload storage; reset clears it so outputs read 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                r_head <= '0;
        else if (w_head_ld_in)    r_head <= w_in;
`ifdef EXMEM_SKID_EN
        else if (w_head_ld_skid)  r_head <= r_skid;
`endif
    end

`ifdef EXMEM_SKID_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_skid <= '0;
        else if (w_skid_ld) r_skid <= w_in;
    end
`endif

    // Saturating stall counter; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall <= '0;
        else if (out_valid && !out_ready && (r_stall != {CNT_W{1'b1}}))
            r_stall <= r_stall + CNT_W'(1);
    end

    assign mem_ctrl     = r_head.ctrl;
    assign mem_pa       = r_head.pa;
    assign mem_alu      = r_head.alu;
    assign mem_rd       = r_head.rd;
    assign mem_pc8      = r_head.pc8;
    assign mem_r31      = r_head.r31;
    assign mem_size     = r_head.ctrl[6:5];
    assign mem_se       = r_head.ctrl[3]  & out_valid;
    assign mem_rw       = r_head.ctrl[4]  & out_valid;
    assign mem_enable   = r_head.ctrl[0]  & out_valid;
    assign rf_enable    = r_head.ctrl[9]  & out_valid;
    assign load_instr   = r_head.ctrl[10] & out_valid;
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_exmem_stage_reg.sv
module tb_exmem_stage_reg;

    localparam int CTRL_W = 22;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int PC8_W  = 9;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0] ex_pa;
    logic [DATA_W-1:0] ex_alu;
    logic [RD_W-1:0]   ex_rd;
    logic [PC8_W-1:0]  ex_pc8;
    logic [4:0]        ex_r31;
    logic              flush;
    logic              out_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [DATA_W-1:0] mem_pa;
    logic [DATA_W-1:0] mem_alu;
    logic [RD_W-1:0]   mem_rd;
    logic [PC8_W-1:0]  mem_pc8;
    logic [4:0]        mem_r31;
    logic [1:0]        mem_size;
    logic              mem_se;
    logic              mem_rw;
    logic              mem_enable;
    logic              rf_enable;
    logic              load_instr;
    logic [CNT_W-1:0]  stall_cycles;

    int tests = 0;
    int fails = 0;
    logic seen77 = 1'b0;

    exmem_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .RD_W(RD_W),
        .PC8_W(PC8_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ex_ctrl(ex_ctrl), .ex_pa(ex_pa), .ex_alu(ex_alu), .ex_rd(ex_rd),
        .ex_pc8(ex_pc8), .ex_r31(ex_r31), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .mem_ctrl(mem_ctrl),
        .mem_pa(mem_pa), .mem_alu(mem_alu), .mem_rd(mem_rd),
        .mem_pc8(mem_pc8), .mem_r31(mem_r31), .mem_size(mem_size),
        .mem_se(mem_se), .mem_rw(mem_rw), .mem_enable(mem_enable),
        .rf_enable(rf_enable), .load_instr(load_instr),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Watch for the flushed payload ever reaching MEM as a valid entry.
    always @(negedge clk) if (out_valid && mem_alu == 32'h77) seen77 <= 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; ex_ctrl = '0; ex_pa = '0; ex_alu = '0; ex_rd = '0;
        ex_pc8 = '0; ex_r31 = '0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        out_ready = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cycles !== '0 ||
            mem_alu !== '0 || mem_ctrl !== '0 || mem_enable !== 1'b0 ||
            rf_enable !== 1'b0 || load_instr !== 1'b0) begin
            fails++;
            $display("FAIL reset: out_valid=%b in_ready=%b stall=%0d alu=%h ctrl=%h want 0/1/0/0/0",
                     out_valid, in_ready, stall_cycles, mem_alu, mem_ctrl);
        end
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_stream();
        do_reset();
        in_valid = 1'b1;
        ex_ctrl  = 22'h060;  // size bits only, no strobes
        for (int i = 1; i <= 4; i++) begin
            ex_alu = i;
            ex_rd  = 5'(i + 3);
            step();
            tests++;
            if (out_valid !== 1'b1 || mem_alu !== 32'(i) || mem_rd !== 5'(i + 3)) begin
                fails++;
                $display("FAIL stream[%0d]: valid=%b alu=%0d rd=%0d want 1/%0d/%0d",
                         i, out_valid, mem_alu, mem_rd, i, i + 3);
            end
        end
        tests++;
        if (mem_size !== 2'd3 || mem_enable !== 1'b0 || stall_cycles !== '0) begin
            fails++;
            $display("FAIL stream_size: size=%0d en=%b stall=%0d want 3/0/0",
                     mem_size, mem_enable, stall_cycles);
        end
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        in_valid = 1'b1; ex_ctrl = 22'h601; ex_alu = 32'hDEADBEEF;
        step();
        in_valid = 1'b0; ex_alu = 32'h0; ex_ctrl = '0; out_ready = 1'b0;
        #1;
        tests++;
`ifdef EXMEM_SKID_EN
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_in_ready: got %b want 1", in_ready);
        end
`else
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
`endif
        repeat (3) step();
        tests++;
        if (out_valid !== 1'b1 || mem_alu !== 32'hDEADBEEF || mem_ctrl !== 22'h601 ||
            mem_enable !== 1'b1 || rf_enable !== 1'b1 || load_instr !== 1'b1 ||
            mem_rw !== 1'b0 || mem_se !== 1'b0 || mem_size !== 2'd0) begin
            fails++;
            $display("FAIL stall_hold: valid=%b alu=%h ctrl=%h en=%b rf=%b ld=%b rw=%b se=%b",
                     out_valid, mem_alu, mem_ctrl, mem_enable, rf_enable, load_instr, mem_rw, mem_se);
        end
        tests++;
        if (stall_cycles !== 4'd3) begin
            fails++;
            $display("FAIL stall_count: got %0d want 3", stall_cycles);
        end
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0 || mem_enable !== 1'b0 || rf_enable !== 1'b0 ||
            load_instr !== 1'b0 || stall_cycles !== 4'd3) begin
            fails++;
            $display("FAIL stall_pop: valid=%b en=%b rf=%b ld=%b stall=%0d want 0/0/0/0/3",
                     out_valid, mem_enable, rf_enable, load_instr, stall_cycles);
        end
    endtask

    task automatic test_skid();
        do_reset();
        in_valid = 1'b1; ex_alu = 32'h11;
        step();
        out_ready = 1'b0; ex_alu = 32'h55;
`ifdef EXMEM_SKID_EN
        step();  // 0x55 goes to skid
        tests++;
        if (in_ready !== 1'b0 || mem_alu !== 32'h11) begin
            fails++;
            $display("FAIL skid_fill: in_ready=%b alu=%h want 0/11", in_ready, mem_alu);
        end
        in_valid = 1'b0; ex_alu = 32'h99;
        out_ready = 1'b1;
        #1;
`else
        step();  // not accepted: in_ready follows out_ready
        tests++;
        if (in_ready !== 1'b0 || mem_alu !== 32'h11) begin
            fails++;
            $display("FAIL skid_block: in_ready=%b alu=%h want 0/11", in_ready, mem_alu);
        end
        out_ready = 1'b1;
        #1;
`endif
        tests++;
        if (out_valid !== 1'b1 || mem_alu !== 32'h11) begin
            fails++;
            $display("FAIL skid_old_head: valid=%b alu=%h want 1/11", out_valid, mem_alu);
        end
        step();
        in_valid = 1'b0; ex_alu = 32'h99;
        tests++;
        if (out_valid !== 1'b1 || mem_alu !== 32'h55) begin
            fails++;
            $display("FAIL skid_next: valid=%b alu=%h want 1/55", out_valid, mem_alu);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL skid_drain: valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        do_reset();
        seen77 = 1'b0;
        in_valid = 1'b1; ex_ctrl = 22'h619; ex_alu = 32'h33;
        step();
        flush = 1'b1; ex_alu = 32'h77; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || mem_enable !== 1'b0 || rf_enable !== 1'b0 ||
            load_instr !== 1'b0 || mem_rw !== 1'b0 || mem_se !== 1'b0) begin
            fails++;
            $display("FAIL flush: valid=%b en=%b rf=%b ld=%b rw=%b se=%b want all 0",
                     out_valid, mem_enable, rf_enable, load_instr, mem_rw, mem_se);
        end
        repeat (2) step();
        tests++;
        if (out_valid !== 1'b0 || seen77 !== 1'b0) begin
            fails++;
            $display("FAIL flush_drop: valid=%b seen77=%b want 0/0", out_valid, seen77);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1; ex_ctrl = 22'h601; ex_alu = 32'hA5;
        step();
        out_ready = 1'b0; ex_alu = 32'hB6;
        step();  // stalled; fills skid when present
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cycles !== '0 ||
            mem_alu !== '0 || mem_ctrl !== '0 || rf_enable !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: valid=%b in_ready=%b stall=%0d alu=%h ctrl=%h want 0/1/0/0/0",
                     out_valid, in_ready, stall_cycles, mem_alu, mem_ctrl);
        end
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_after: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        in_valid = 1'b1; ex_alu = 32'h5A;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (14) step();
        tests++;
        if (stall_cycles !== 4'd14) begin
            fails++;
            $display("FAIL sat_14: got %0d want 14", stall_cycles);
        end
        repeat (6) step();
        tests++;
        if (stall_cycles !== 4'd15 || mem_alu !== 32'h5A) begin
            fails++;
            $display("FAIL sat_20: stall=%0d alu=%h want 15/5a", stall_cycles, mem_alu);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++;
        if (stall_cycles !== 4'd15 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL sat_flush: stall=%0d valid=%b want 15/0", stall_cycles, out_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_stall_hold();
        test_skid();
        test_flush();
        test_async_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exmem_stage_reg.md
# exmem_stage_reg

- Parametrised EX/MEM pipeline register with a valid/ready handshake, stall and flush support, and an optional skid entry.
- Captures the EX-stage payload (control word, store data, ALU result, destination register, PC+8, R31 index) and presents it to MEM one cycle later.
- Also presents the MEM strobes decoded from the control word, gated by valid.
- Replaces the fixed always-capture EX/MEM register so hazard logic can stall MEM or squash EX results.

## Interface

Parameters:
- CTRL_W, 22: control word width; must be ≥ 11.
- DATA_W, 32: width of PA and ALU payloads.
- RD_W, 5: destination-register index width.
- PC8_W, 9: PC+8 payload width.
- CNT_W, 16: stall-counter width.

Ports (reset reset, asynchronous, active-high; clock clk):
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  register can accept this cycle.
- ex_ctrl  in  CTRL_W  EX control word.
- ex_pa  in  DATA_W  store data / operand A.
- ex_alu  in  DATA_W  ALU result.
- ex_rd  in  RD_W  destination register.
- ex_pc8  in  PC8_W  PC+8.
- ex_r31  in  5  link register index.
- flush  in  1  squash all held entries.
- out_ready  in  1  MEM consumes the head this cycle; low means stall.
- out_valid  out  1  head entry valid.
- mem_ctrl  out  CTRL_W  head control word.
- mem_pa, mem_alu  out  DATA_W  head payloads.
- mem_rd  out  RD_W  head destination register.
- mem_pc8  out  PC8_W  head PC+8.
- mem_r31  out  5  head link register index.
- mem_size  out  2  mem_ctrl[6:5].
- mem_se  out  1  mem_ctrl[3] & out_valid.
- mem_rw  out  1  mem_ctrl[4] & out_valid.
- mem_enable  out  1  mem_ctrl[0] & out_valid.
- rf_enable  out  1  mem_ctrl[9] & out_valid.
- load_instr  out  1  mem_ctrl[10] & out_valid.
- stall_cycles  out  CNT_W  saturating stall counter.

## Operation

- Storage:
  - Head entry: drives all mem_* outputs.
  - Skid entry: present only with the macro.
- Occupancy states:
  - EMPTY: out_valid=0.
  - ONE: head valid, skid empty.
  - TWO: head and skid valid; skid builds only.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Transitions, non-flush:
  - EMPTY + accept → ONE.
  - ONE + pop, no accept → EMPTY.
  - ONE + pop + accept → ONE; head loads the new entry.
  - ONE + no pop + accept → TWO; new entry goes to skid (skid builds only).
  - TWO + pop → ONE; skid moves to head. No accept is possible in TWO.
  - Otherwise hold. Held payloads do not change while stalled.
- flush: next state EMPTY. Flush has priority over a simultaneous accept, and the entry accepted in that cycle is dropped. Payload registers may keep stale data; all strobes are 0 because out_valid=0.
- Decoded strobes are forced to 0 whenever out_valid=0, so bubbles never write memory or the register file.
- mem_size is not gated.
- stall_cycles:
  - Increments on every cycle with out_valid & ~out_ready.
  - Holds at 2^CNT_W−1.
  - Cleared only by reset; flush does not clear it.

## Timing

- Latency: one cycle. An entry accepted at edge N is on mem_* after edge N.
- in_ready:
  - Without macro: combinational, = out_ready | ~out_valid.
  - With macro: registered, = ~skid_valid. No combinational path from out_ready.
- While reset is asserted and after its release, all outputs are 0 except in_ready=1. State is EMPTY and stall_cycles=0.
- Reset asserted mid-operation discards both entries immediately, asynchronously.

## Configuration

- EXMEM_SKID_EN defined:
  - Skid entry and state TWO are compiled in.
  - in_ready is registered, which breaks the MEM→EX ready timing path.
  - Sustains full throughput across a one-cycle stall.
- Undefined:
  - No skid storage; TWO is unreachable.
  - in_ready is combinational as above.

## Test plan

- Streaming: reset, then in_valid=1 with out_ready=1 for 4 cycles, ex_alu=1,2,3,4. mem_alu shows 1,2,3,4 one cycle later each; out_valid stays 1; stall_cycles=0.
- Stall hold: load ex_ctrl=0x601 (bits 0,9,10 set) and ex_alu=0xDEADBEEF, then out_ready=0 for 3 cycles. Required:
  - Head holds 0xDEADBEEF.
  - mem_enable=1, rf_enable=1, load_instr=1.
  - stall_cycles=3.
  - Without macro: in_ready=0 during the stall.
- Skid, with macro: head full, out_ready=0, accept ex_alu=0x55. Required:
  - in_ready falls to 0 the next cycle.
  - After out_ready=1, mem_alu shows the old head, then 0x55.
  - No entry is lost or duplicated.
- Flush priority: in ONE, assert flush and in_valid together (ex_alu=0x77). Next cycle:
  - out_valid=0 and all strobes=0.
  - 0x77 never appears on the outputs.
- Async reset mid-stall: assert reset between edges while in TWO (with macro) or ONE. Required:
  - Outputs go to 0 immediately, in_ready=1, stall_cycles=0.
- Saturation: CNT_W=4, stall for 20 cycles. stall_cycles sticks at 15.
